// File: rtl/axis_result_packer_pkg.sv
// Shared accelerator constants and FSM encoding for the class-sum packer.
// Geometry of the output stream and the frame-length check are defined here.
package axis_result_packer_pkg;

  localparam int ACC_DATA_WIDTH  = 128;
  localparam int ACC_SUM_WIDTH   = 16;
  localparam int ACC_LANES       = ACC_DATA_WIDTH / ACC_SUM_WIDTH;
  localparam int ACC_NUM_CLASSES = 10;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_SEND = 1'b1
  } pack_state_e;

  // A frame is malformed if it ends early, or if the expected final class is not flagged last.
  function automatic logic len_error(input int cls_idx, input logic last, input int num_classes);
    return last ? (cls_idx != num_classes - 1) : (cls_idx == num_classes - 1);
  endfunction

endpackage

// File: rtl/axis_result_packer.sv
// Packs a stream of signed class sums into AXI-Stream beats, LANES sums per beat,
// closing a beat early on the final sum of a frame.
module axis_result_packer
  import axis_result_packer_pkg::*;
#(
  parameter int DATA_WIDTH  = ACC_DATA_WIDTH,
  parameter int SUM_WIDTH   = ACC_SUM_WIDTH,
  parameter int NUM_CLASSES = ACC_NUM_CLASSES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SUM_WIDTH-1:0]  sum_data,
  input  logic                  sum_valid,
  input  logic                  sum_last,
  output logic                  sum_ready,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic                  M_AXIS_TLAST,
  output logic [15:0]           frame_count,
  output logic                  err_len
);

  localparam int LANES = DATA_WIDTH / SUM_WIDTH;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

  pack_state_e           state_q, state_d;
  logic [LW-1:0]         lane_q, lane_d;
  logic [15:0]           class_q, class_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  last_q, last_d;
  logic [15:0]           fcnt_q, fcnt_d;
  logic                  err_q, err_d;

  logic sum_acc, beat_acc;

  assign sum_acc  = sum_valid & sum_ready;
  assign beat_acc = M_AXIS_TVALID & M_AXIS_TREADY;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FILL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: if (sum_acc && (lane_q == LW'(LANES - 1) || sum_last)) state_d = ST_SEND;
      ST_SEND: if (M_AXIS_TREADY) state_d = ST_FILL;
      default: state_d = ST_FILL;
    endcase
  end

  always_comb begin
    sum_ready     = (state_q == ST_FILL);
    M_AXIS_TVALID = (state_q == ST_SEND);
  end

  // The buffer only changes in FILL, so TDATA/TLAST hold while a beat is stalled.
  always_comb begin
    buf_d   = buf_q;
    lane_d  = lane_q;
    class_d = class_q;
    last_d  = last_q;
    fcnt_d  = fcnt_q;
    err_d   = err_q;
    if (sum_acc) begin
      buf_d[lane_q*SUM_WIDTH +: SUM_WIDTH] = sum_data;
      lane_d  = lane_q + 1'b1;
      class_d = class_q + 16'd1;
      last_d  = sum_last;
      if (len_error(int'(class_q), sum_last, NUM_CLASSES)) err_d = 1'b1;
    end
    if (beat_acc) begin
      buf_d  = '0;
      lane_d = '0;
      last_d = 1'b0;
      if (last_q) begin
        class_d = '0;
        fcnt_d  = fcnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q   <= '0;
      lane_q  <= '0;
      class_q <= '0;
      last_q  <= 1'b0;
      fcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      lane_q  <= lane_d;
      class_q <= class_d;
      last_q  <= last_d;
      fcnt_q  <= fcnt_d;
      err_q   <= err_d;
    end
  end

  assign M_AXIS_TDATA = buf_q;
  assign M_AXIS_TLAST = last_q;
  assign frame_count  = fcnt_q;
  assign err_len      = err_q;

endmodule

// File: tb/tb_axis_result_packer.sv
// Directed and randomized-backpressure checks of the class-sum packer.
module tb_axis_result_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  sum_data;
  logic         sum_valid;
  logic         sum_last;
  logic         sum_ready;
  logic [127:0] M_AXIS_TDATA;
  logic         M_AXIS_TVALID;
  logic         M_AXIS_TREADY;
  logic         M_AXIS_TLAST;
  logic [15:0]  frame_count;
  logic         err_len;

  int errors = 0;
  int checks = 0;
  logic rnd_en = 1'b0;

  logic [127:0] bq_data[$];
  logic         bq_last[$];
  logic [127:0] eq_data[$];
  logic         eq_last[$];

  axis_result_packer dut (
    .clk(clk), .rst(rst),
    .sum_data(sum_data), .sum_valid(sum_valid), .sum_last(sum_last), .sum_ready(sum_ready),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
    .M_AXIS_TLAST(M_AXIS_TLAST), .frame_count(frame_count), .err_len(err_len)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && M_AXIS_TVALID && M_AXIS_TREADY) begin
      bq_data.push_back(M_AXIS_TDATA);
      bq_last.push_back(M_AXIS_TLAST);
    end

  always @(negedge clk)
    if (rnd_en) M_AXIS_TREADY = 1'($urandom_range(0, 1));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic last);
    int n = 0;
    sum_data  = d;
    sum_last  = last;
    sum_valid = 1'b1;
    while (!sum_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("push_timeout", 128'(n < 200), 128'd1);
    @(negedge clk);
    sum_valid = 1'b0;
    sum_last  = 1'b0;
  endtask

  task automatic push_range(input int first, input int cnt, input int last_at);
    for (int i = 0; i < cnt; i++) push(16'(first + i), (i == last_at));
  endtask

  task automatic wait_beats(input int n, input string tag);
    int c = 0;
    while (bq_data.size() < n && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check(tag, 128'(bq_data.size() >= n), 128'd1);
  endtask

  task automatic clear_q();
    bq_data.delete();
    bq_last.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_q();
  endtask

  task automatic check_beat(input int idx, input string tag, input logic [127:0] d, input logic l);
    if (bq_data.size() > idx) begin
      check({tag, "_data"}, bq_data[idx], d);
      check({tag, "_last"}, 128'(bq_last[idx]), 128'(l));
    end else check({tag, "_missing"}, 128'(bq_data.size()), 128'(idx + 1));
  endtask

  initial begin
    logic [127:0] held;
    logic [15:0]  s[10];
    logic [127:0] b;
    rst = 1'b1; sum_data = '0; sum_valid = 1'b0; sum_last = 1'b0; M_AXIS_TREADY = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_tvalid", 128'(M_AXIS_TVALID), 128'd0);
    check("rst_tdata", M_AXIS_TDATA, 128'd0);
    check("rst_fcnt", 128'(frame_count), 128'd0);
    check("rst_err", 128'(err_len), 128'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 128'(sum_ready), 128'd1);

    // Basic 10-class frame, no backpressure
    clear_q();
    push_range(1, 10, 9);
    wait_beats(2, "f1_wait");
    check_beat(0, "f1_b0", 128'h0008_0007_0006_0005_0004_0003_0002_0001, 1'b0);
    check_beat(1, "f1_b1", 128'h0000_0000_0000_0000_0000_0000_000a_0009, 1'b1);
    check("f1_fcnt", 128'(frame_count), 128'd1);
    check("f1_err", 128'(err_len), 128'd0);

    // Stalled beat holds for five cycles, accepted on the sixth
    clear_q();
    M_AXIS_TREADY = 1'b0;
    push_range(11, 8, -1);
    held = 128'h0012_0011_0010_000f_000e_000d_000c_000b;
    check("st_tvalid0", 128'(M_AXIS_TVALID), 128'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("st_tdata", M_AXIS_TDATA, held);
      check("st_tlast", 128'(M_AXIS_TLAST), 128'd0);
      check("st_tvalid", 128'(M_AXIS_TVALID), 128'd1);
      check("st_ready", 128'(sum_ready), 128'd0);
    end
    M_AXIS_TREADY = 1'b1;
    @(negedge clk);
    check("st_accepted", 128'(bq_data.size()), 128'd1);
    check("st_ready_back", 128'(sum_ready), 128'd1);
    push_range(19, 2, 1);
    wait_beats(2, "st_wait");
    check_beat(0, "st_b0", held, 1'b0);
    check_beat(1, "st_b1", 128'h0000_0000_0000_0000_0000_0000_0014_0013, 1'b1);
    check("st_fcnt", 128'(frame_count), 128'd2);

    // Negative class sum stays within its lane
    clear_q();
    push(16'hFFFF, 1'b0);
    push_range(1, 9, 8);
    wait_beats(2, "neg_wait");
    check_beat(0, "neg_b0", 128'h0007_0006_0005_0004_0003_0002_0001_ffff, 1'b0);
    check_beat(1, "neg_b1", 128'h0000_0000_0000_0000_0000_0000_0009_0008, 1'b1);
    check("neg_err", 128'(err_len), 128'd0);

    // Short frame flags err_len, which then stays set
    clear_q();
    push_range(5, 3, 2);
    wait_beats(1, "short_wait");
    check_beat(0, "short_b0", 128'h0000_0000_0000_0000_0000_0007_0006_0005, 1'b1);
    check("short_err", 128'(err_len), 128'd1);
    check("short_fcnt", 128'(frame_count), 128'd4);
    clear_q();
    push_range(1, 10, 9);
    wait_beats(2, "after_wait");
    check_beat(0, "after_b0", 128'h0008_0007_0006_0005_0004_0003_0002_0001, 1'b0);
    check_beat(1, "after_b1", 128'h0000_0000_0000_0000_0000_0000_000a_0009, 1'b1);
    check("after_err", 128'(err_len), 128'd1);
    check("after_fcnt", 128'(frame_count), 128'd5);

    // Reset during a stalled beat
    M_AXIS_TREADY = 1'b0;
    push_range(1, 8, -1);
    check("mr_tvalid_pre", 128'(M_AXIS_TVALID), 128'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mr_tvalid", 128'(M_AXIS_TVALID), 128'd0);
    check("mr_tdata", M_AXIS_TDATA, 128'd0);
    check("mr_tlast", 128'(M_AXIS_TLAST), 128'd0);
    check("mr_fcnt", 128'(frame_count), 128'd0);
    check("mr_err", 128'(err_len), 128'd0);
    rst = 1'b0;
    M_AXIS_TREADY = 1'b1;
    clear_q();
    @(negedge clk);
    check("mr_ready", 128'(sum_ready), 128'd1);
    push_range(1, 10, 9);
    wait_beats(2, "mr_wait");
    check_beat(0, "mr_b0", 128'h0008_0007_0006_0005_0004_0003_0002_0001, 1'b0);
    check_beat(1, "mr_b1", 128'h0000_0000_0000_0000_0000_0000_000a_0009, 1'b1);
    check("mr_fcnt1", 128'(frame_count), 128'd1);

    // 200 frames with random backpressure against a scoreboard
    do_reset();
    rnd_en = 1'b1;
    for (int f = 0; f < 200; f++) begin
      for (int c = 0; c < 10; c++) s[c] = 16'($urandom);
      b = '0;
      for (int c = 0; c < 8; c++) b[c*16 +: 16] = s[c];
      eq_data.push_back(b); eq_last.push_back(1'b0);
      b = '0;
      for (int c = 0; c < 2; c++) b[c*16 +: 16] = s[8 + c];
      eq_data.push_back(b); eq_last.push_back(1'b1);
      for (int c = 0; c < 10; c++) push(s[c], (c == 9));
    end
    wait_beats(400, "rnd_wait");
    rnd_en = 1'b0;
    M_AXIS_TREADY = 1'b1;
    @(negedge clk);
    check("rnd_count", 128'(bq_data.size()), 128'd400);
    for (int i = 0; i < 400; i++) check_beat(i, "rnd", eq_data[i], eq_last[i]);
    check("rnd_fcnt", 128'(frame_count), 128'd200);
    check("rnd_err", 128'(err_len), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
